// File: rtl/pf_pkg.sv
// Shared definitions for the prefetch fill engine: address geometry helpers,
// FSM state encoding and statistics counter width.
package pf_pkg;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FILL
   } pf_state_e;

   function automatic int offset_bits(input int block_size_byte);
      return $clog2(block_size_byte);
   endfunction

   function automatic int line_w(input int block_size_byte);
      return ADDR_W - $clog2(block_size_byte);
   endfunction

endpackage

// File: rtl/pf_req_fifo.sv
// Circular request queue with a parallel compare of all live entries against
// an incoming line, used for duplicate suppression.
module pf_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 28
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty,
   input  logic [W-1:0] match_data,
   output logic         match
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [PW-1:0] age;

   assign head  = mem_q[rd_q];
   assign full  = (cnt_q == (PW+1)'(DEPTH));
   assign empty = (cnt_q == '0);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // An entry is live when its distance from the read pointer is below the count.
   always_comb begin
      match = 1'b0;
      age   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age = PW'(i) - rd_q;
         if (({1'b0, age} < cnt_q) && (mem_q[i] == match_data)) match = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/prefetch_fill_engine.sv
// Prefetch responder: queues and de-duplicates line requests, issues one memory
// read at a time, and returns each line as a single-cycle fill.
module prefetch_fill_engine
   import pf_pkg::*;
#(
   parameter  int block_size_byte    = 16,
   parameter  int fifo_depth         = 4,
   localparam int block_offset_index = offset_bits(block_size_byte),
   localparam int line_width         = line_w(block_size_byte)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         pf_req_valid,
   input  logic [line_width-1:0]        pf_req_line,
   output logic                         pf_req_ready,
   output logic                         mem_req_valid,
   output logic [31:0]                  mem_req_addr,
   input  logic                         mem_req_ready,
   input  logic                         mem_resp_valid,
   input  logic [8*block_size_byte-1:0] mem_resp_data,
   output logic                         fill_valid,
   output logic [line_width-1:0]        fill_line,
   output logic [8*block_size_byte-1:0] fill_data,
   output logic [CNT_W-1:0]             issue_count,
   output logic [CNT_W-1:0]             drop_count
);

   localparam int DW = 8 * block_size_byte;

   pf_state_e             state_q, state_d;
   logic [line_width-1:0] inflight_q, inflight_d;
   logic [DW-1:0]         data_q, data_d;
   logic [CNT_W-1:0]      issue_q, issue_d, drop_q, drop_d;

   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_match;
   logic [line_width-1:0] fifo_head;
   logic                  accept, dup;

   pf_req_fifo #(
      .DEPTH (fifo_depth),
      .W     (line_width)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (fifo_push),
      .push_data  (pf_req_line),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .match_data (pf_req_line),
      .match      (fifo_match)
   );

   always_comb begin
      state_d    = state_q;
      inflight_d = inflight_q;
      data_d     = data_q;
      issue_d    = issue_q;
      drop_d     = drop_q;
      fifo_pop   = 1'b0;

      // Match sees pre-edge contents, so a head popped this cycle still counts.
      accept    = pf_req_valid && !fifo_full;
      dup       = fifo_match || ((state_q != S_IDLE) && (pf_req_line == inflight_q));
      fifo_push = accept && !dup;
      if (accept && dup && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               inflight_d = fifo_head;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (mem_req_ready) begin
               state_d = S_WAIT;
               if (issue_q != '1) issue_d = issue_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               data_d  = mem_resp_data;
               state_d = S_FILL;
            end
         end
         S_FILL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         inflight_q <= '0;
         data_q     <= '0;
         issue_q    <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         data_q     <= data_d;
         issue_q    <= issue_d;
         drop_q     <= drop_d;
      end
   end

   assign pf_req_ready  = !fifo_full;
   assign mem_req_valid = (state_q == S_ISSUE);
   assign mem_req_addr  = {inflight_q, {block_offset_index{1'b0}}};
   assign fill_valid    = (state_q == S_FILL);
   assign fill_line     = fill_valid ? inflight_q : '0;
   assign fill_data     = fill_valid ? data_q : '0;
   assign issue_count   = issue_q;
   assign drop_count    = drop_q;

endmodule
